mem_responder: RTL
==================

Name: mem_responder

Overview:
Memory-side responder for the CPU controller's mem_cmd/mem_addr/write_data bus. It services CPU reads and writes to a 256x16 synchronous RAM and to two memory-mapped I/O registers: LED output and switch input. It produces registered read data with a one-cycle valid pulse and flags protocol errors. It sits between the CPU top level and the board I/O, replacing ad-hoc RAM/tristate glue.

Parameters:
DATA_W, 16, word width
ADDR_W, 9, CPU address width
RAM_AW, 8, RAM index width (256 words)
LED_ADDR, 9'h100, LED register address
SW_ADDR, 9'h140, switch register address

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mem_cmd  in  2  00 NONE, 01 READ, 10 WRITE, 11 illegal
mem_addr  in  ADDR_W  access address
write_data  in  DATA_W  write data, sampled with WRITE
read_data  out  DATA_W  registered read result
rd_valid  out  1  one-cycle pulse: read_data updated by a READ
sw_in  in  8  asynchronous board switches
led_out  out  8  LED register
bus_err  out  1  sticky error flag
err_addr  out  ADDR_W  address of the first error

Behaviour:
- Reset values: read_data=0, rd_valid=0, led_out=0, bus_err=0, err_addr=0, switch synchroniser=0, FSM=IDLE. RAM contents are not reset.
- Decode (combinational on mem_addr):
  - RAM hit: mem_addr[8]==0.
  - LED hit: mem_addr==LED_ADDR.
  - SW hit: mem_addr==SW_ADDR.
  - Anything else: miss.
- FSM states: IDLE, RD_RESP, WR_DONE. Every edge samples mem_cmd, so the next state depends only on the current cmd.
  - READ: next state RD_RESP.
  - WRITE: next state WR_DONE.
  - NONE or illegal: next state IDLE.
  - Back-to-back commands are legal every cycle. A held READ produces a rd_valid pulse every cycle.
- READ sampled at edge N:
  - read_data loads at edge N: RAM[addr[7:0]], or {8'h00, sw_sync} for SW, or {8'h00, led_out} for LED, or 16'h0000 for a miss.
  - rd_valid is high for the cycle after edge N (state RD_RESP).
  - Read latency is 1 cycle. This matches a CPU that asserts READ in one state and loads in the next.
- WRITE sampled at edge N:
  - RAM hit: RAM[addr[7:0]] is written at edge N.
  - LED hit: led_out <= write_data[7:0] at edge N.
  - SW hit or miss: no state changes except error logging.
  - read_data is unchanged.
- NONE: no side effects. read_data holds its value. rd_valid=0.
- Errors, logged at the sampling edge:
  - Triggers: illegal cmd 11; READ/WRITE to a miss; WRITE to SW.
  - bus_err is set and sticky until rst.
  - err_addr captures only the first error's address.
  - Simultaneous new errors while bus_err=1 do not overwrite err_addr.
- Switch input: two-flop synchroniser, so sw_sync lags sw_in by 2 edges. A READ samples the synchronised value.
- Read-after-write to the same address on consecutive cycles returns the new data, because the write commits before the next READ edge.
- rst asserted mid-access:
  - The in-flight rd_valid is suppressed.
  - An access sampled in the same cycle as rst is ignored; RAM is not written.
  - led_out and error state clear.

Optional Feature:
MEM_RESP_STATS_EN
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], reset to 0.
  - Each increments on every sampled READ/WRITE, including errored ones.
  - Counters saturate at 16'hFFFF; no wrap.
- Undefined: the ports and logic are absent.

Decomposition:
- Package mem_bus_pkg holds:
  - the mem_cmd encodings MNONE/MREAD/MWRITE as a typedef'd enum logic [1:0];
  - the LED_ADDR/SW_ADDR constants;
  - the responder state enum.
- The CPU controller imports the same package, so the encodings cannot drift.
- One natural sub-module: ram_1rw (parameterised single-port synchronous RAM, registered read, write-first). The decode, MMIO, error and FSM logic stay in mem_responder.

Test Plan:
- WRITE 16'hBEEF @9'h005, then READ 9'h005 on the next cycle -> read_data=16'hBEEF, rd_valid high exactly 1 cycle after the READ edge.
- WRITE 16'h12A5 @LED_ADDR -> led_out=8'hA5 after that edge. READ LED_ADDR -> read_data=16'h00A5.
- sw_in=8'h3C, wait 3 cycles, READ SW_ADDR -> read_data=16'h003C. READ issued 1 cycle after the sw_in change -> old value.
- Three back-to-back READs at 9'h001/9'h002/9'h003 (preloaded 1/2/3) -> read_data=1,2,3 on consecutive cycles, rd_valid high 3 cycles.
- mem_cmd=2'b11 @9'h0AA, then READ 9'h180 -> bus_err=1, err_addr=9'h0AA (not 9'h180), read_data=0. rst clears both.
- rst asserted in the same cycle as WRITE 16'h5555 @9'h010 -> a following READ 9'h010 returns the prior contents, and rd_valid is not asserted during rst.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions for the CPU controller and the memory responder.
// Contents:
//   mem_cmd_e      mem_cmd encodings (00 none, 01 read, 10 write; 11 is illegal)
//   LED_ADDR       address of the LED output register
//   SW_ADDR        address of the switch input register
//   resp_state_e   responder FSM states
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_RESP = 2'b01,
    WR_DONE = 2'b10
  } resp_state_e;

endpackage

// File: rtl/ram_1rw.sv
// Single-port synchronous RAM with a registered read port.
// Write-first: when re and we are both asserted, rdata takes the write data.
// rdata holds its value whenever re is low. Contents are not reset.
// Ports:
//   clk    clock
//   re     read enable (loads rdata)
//   we     write enable
//   addr   word address
//   wdata  write data
//   rdata  registered read data
module ram_1rw #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU mem_cmd/mem_addr/write_data bus.
// Services a 256x16 RAM (mem_addr[8]==0), an LED output register at LED_ADDR
// and a switch input register at SW_ADDR. Reads return registered data with a
// one-cycle rd_valid pulse; protocol errors set a sticky flag and log the
// address of the first offending access.
// Optional build macro: MEM_RESP_STATS_EN adds saturating rd_count/wr_count.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   mem_cmd       00 none, 01 read, 10 write, 11 illegal
//   mem_addr      access address
//   write_data    write data, sampled with a write
//   read_data     registered read result
//   rd_valid      one-cycle pulse after a read is sampled
//   sw_in         asynchronous board switches
//   led_out       LED register
//   bus_err       sticky error flag
//   err_addr      address of the first error
//   rd_count      (MEM_RESP_STATS_EN) sampled reads, saturating
//   wr_count      (MEM_RESP_STATS_EN) sampled writes, saturating
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        RAM_AW   = 8,
  parameter logic [ADDR_W-1:0]  LED_ADDR = ADDR_W'(mem_bus_pkg::LED_ADDR),
  parameter logic [ADDR_W-1:0]  SW_ADDR  = ADDR_W'(mem_bus_pkg::SW_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  resp_state_e state, state_next;

  logic ram_hit, led_hit, sw_hit, miss;
  logic is_rd, is_wr, is_bad, acc_err;
  logic ram_re, ram_we;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] mmio_q;
  logic              rd_from_ram;
  logic [7:0]        sw_meta, sw_sync;

  // Address decode and command classification
  always_comb begin
    ram_hit = ~mem_addr[ADDR_W-1];
    led_hit = (mem_addr == LED_ADDR);
    sw_hit  = (mem_addr == SW_ADDR);
    miss    = ~(ram_hit | led_hit | sw_hit);
    is_rd   = (mem_cmd == MREAD);
    is_wr   = (mem_cmd == MWRITE);
    is_bad  = (mem_cmd == 2'b11);
    acc_err = is_bad | ((is_rd | is_wr) & miss) | (is_wr & sw_hit);
    ram_re  = ~rst & is_rd & ram_hit;
    ram_we  = ~rst & is_wr & ram_hit;
  end

  ram_1rw #(
    .DW(DATA_W),
    .AW(RAM_AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (mem_addr[RAM_AW-1:0]),
    .wdata (write_data),
    .rdata (ram_q)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state depends only on the command sampled this edge
  always_comb begin
    state_next = IDLE;
    rd_valid   = 1'b0;
    case (mem_cmd)
      MREAD:   state_next = RD_RESP;
      MWRITE:  state_next = WR_DONE;
      default: state_next = IDLE;
    endcase
    // rst squashes a response that is already in flight
    rd_valid = (state == RD_RESP) & ~rst;
  end

  // RAM data lives in the RAM's own output register; MMIO and miss results
  // live in mmio_q. rd_from_ram remembers which one the last read loaded, so
  // read_data is a mux of registered values and holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_from_ram <= 1'b0;
      mmio_q      <= '0;
    end else if (is_rd) begin
      rd_from_ram <= ram_hit;
      if (sw_hit)       mmio_q <= DATA_W'(sw_sync);
      else if (led_hit) mmio_q <= DATA_W'(led_out);
      else              mmio_q <= '0;
    end
  end

  assign read_data = rd_from_ram ? ram_q : mmio_q;

  // Two-flop switch synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (rst)                  led_out <= '0;
    else if (is_wr & led_hit) led_out <= write_data[7:0];
  end

  // Sticky error flag; only the first error's address is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (acc_err) begin
      bus_err <= 1'b1;
      if (!bus_err) err_addr <= mem_addr;
    end
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (is_rd && rd_count != '1) rd_count <= rd_count + 16'd1;
      if (is_wr && wr_count != '1) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
